// File: rtl/mlp_pkg.sv
// Shared types and fixed-point defaults for the MLP datapath blocks.
package mlp_pkg;

   localparam int FP_TOTAL_BITS = 16;
   localparam int FP_FRAC_BITS  = 8;

   localparam logic signed [FP_TOTAL_BITS-1:0] FP_ZERO = '0;

   typedef enum logic [1:0] {
      ACT_RELU      = 2'd0,
      ACT_RELU_CLIP = 2'd1,
      ACT_LEAKY     = 2'd2,
      ACT_IDENTITY  = 2'd3
   } act_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } act_state_e;

endpackage

// File: rtl/act_lane.sv
// Per-element activation, purely combinational. The LEAKY shifter exists only
// when ACT_LEAKY_EN is defined; otherwise mode LEAKY falls through to ReLU.
module act_lane
   import mlp_pkg::*;
#(
   parameter int W = FP_TOTAL_BITS
`ifdef ACT_LEAKY_EN
   ,
   parameter int LEAK_SHIFT = 3
`endif
) (
   input  logic signed [W-1:0] x,
   input  act_mode_e           mode,
   input  logic signed [W-1:0] clip_val,
   input  logic                pad,
   output logic signed [W-1:0] y
);

   logic signed [W-1:0] zero;
   logic signed [W-1:0] clip_min;

   assign zero     = W'(FP_ZERO);
   // min first, then floor at zero, so a negative clip_val forces 0
   assign clip_min = (x < clip_val) ? x : clip_val;

   always_comb begin
      y = zero;
      if (!pad) begin
         case (mode)
            ACT_RELU_CLIP: y = clip_min[W-1] ? zero : clip_min;
            ACT_IDENTITY:  y = x;
`ifdef ACT_LEAKY_EN
            ACT_LEAKY:     y = x[W-1] ? (x >>> LEAK_SHIFT) : x;
`endif
            default:       y = x[W-1] ? zero : x;
         endcase
      end
   end

endmodule

// File: rtl/act_stream.sv
// Streaming multi-lane activation unit: FSM, beat counter, one-deep output
// register. Optional LEAKY mode is compiled in with ACT_LEAKY_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start, in_ready low
// ST_RUN   | accepting beats, one output register slot
// ST_DRAIN | final beat held in output register until taken
// ST_DONE  | one-cycle done pulse
module act_stream #(
   parameter int NUM_ELEMS     = 784,
   parameter int LANES         = 4,
   parameter int FP_TOTAL_BITS = mlp_pkg::FP_TOTAL_BITS,
   parameter int FP_FRAC_BITS  = mlp_pkg::FP_FRAC_BITS,
   parameter int LEAK_SHIFT    = 3
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [1:0]                     mode,
   input  logic [FP_TOTAL_BITS-1:0]       clip_val,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [LANES*FP_TOTAL_BITS-1:0] in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [LANES*FP_TOTAL_BITS-1:0] out_data,
   output logic                           out_last,
   output logic                           busy,
   output logic                           done
);
   import mlp_pkg::*;

   localparam int BEATS = (NUM_ELEMS + LANES - 1) / LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int DW    = LANES * FP_TOTAL_BITS;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   if (FP_FRAC_BITS >= FP_TOTAL_BITS || LEAK_SHIFT >= FP_TOTAL_BITS) begin : g_bad_cfg
      $error("act_stream: fractional bits or leak shift exceed word width");
   end

   act_state_e               state_q, state_d;
   act_mode_e                mode_q, mode_d;
   logic [FP_TOTAL_BITS-1:0] clip_q, clip_d;
   logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
   logic                     out_valid_q, out_valid_d;
   logic                     out_last_q, out_last_d;
   logic [DW-1:0]            out_data_q, out_data_d;
   logic [DW-1:0]            lane_res;
   logic [LANES-1:0]         lane_pad;
   logic                     accept;
   logic                     handoff;

   assign handoff  = out_valid_q && out_ready;
   assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign lane_pad[i] = (int'(beat_cnt_q) * LANES + i) >= NUM_ELEMS;

      act_lane #(
         .W          (FP_TOTAL_BITS)
`ifdef ACT_LEAKY_EN
         ,
         .LEAK_SHIFT (LEAK_SHIFT)
`endif
      ) u_lane (
         .x        (in_data[i*FP_TOTAL_BITS +: FP_TOTAL_BITS]),
         .mode     (mode_q),
         .clip_val (clip_q),
         .pad      (lane_pad[i]),
         .y        (lane_res[i*FP_TOTAL_BITS +: FP_TOTAL_BITS])
      );
   end

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      clip_d      = clip_q;
      beat_cnt_d  = beat_cnt_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;

      if (handoff) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
      // a new beat may land in the same cycle the old one leaves
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = lane_res;
         out_last_d  = (beat_cnt_q == LAST_BEAT);
         beat_cnt_d  = beat_cnt_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_RUN;
               mode_d     = act_mode_e'(mode);
               clip_d     = clip_val;
               beat_cnt_d = '0;
            end
         end
         ST_RUN:   if (accept && (beat_cnt_q == LAST_BEAT)) state_d = ST_DRAIN;
         ST_DRAIN: if (handoff && out_last_q) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mode_q      <= ACT_RELU;
         clip_q      <= '0;
         beat_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         clip_q      <= clip_d;
         beat_cnt_q  <= beat_cnt_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_act_stream.sv
// Bench for act_stream: three instances (8, 6 and 784 elements) share stimulus,
// one is selected at a time; a queue scoreboard checks every output beat.
module tb_act_stream;

   localparam int DW = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    mode;
   logic [15:0]   clip_val;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          out_ready;
   int            sel;

   logic          ir_v [3];
   logic          ov_v [3];
   logic          ol_v [3];
   logic          bs_v [3];
   logic          dn_v [3];
   logic [DW-1:0] od_v [3];

   logic          in_ready, out_valid, out_last, busy, done;
   logic [DW-1:0] out_data;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;
   exp_t sbq [$];

   typedef struct {
      int          sel;
      logic [1:0]  mode;
      logic [15:0] clip;
      logic [127:0] din;
      logic [127:0] dexp;
   } vec_t;
   vec_t tbl [$];

   logic [15:0] vin  [0:799];
   logic [15:0] vexp [0:799];

   always #5 clk = ~clk;

   act_stream #(.NUM_ELEMS(8), .LANES(4)) u_dut8 (
      .clk(clk), .reset(reset), .start(start && sel == 0), .mode(mode), .clip_val(clip_val),
      .in_valid(in_valid && sel == 0), .in_ready(ir_v[0]), .in_data(in_data),
      .out_valid(ov_v[0]), .out_ready(out_ready), .out_data(od_v[0]), .out_last(ol_v[0]),
      .busy(bs_v[0]), .done(dn_v[0]));

   act_stream #(.NUM_ELEMS(6), .LANES(4)) u_dut6 (
      .clk(clk), .reset(reset), .start(start && sel == 1), .mode(mode), .clip_val(clip_val),
      .in_valid(in_valid && sel == 1), .in_ready(ir_v[1]), .in_data(in_data),
      .out_valid(ov_v[1]), .out_ready(out_ready), .out_data(od_v[1]), .out_last(ol_v[1]),
      .busy(bs_v[1]), .done(dn_v[1]));

   act_stream #(.NUM_ELEMS(784), .LANES(4)) u_dut784 (
      .clk(clk), .reset(reset), .start(start && sel == 2), .mode(mode), .clip_val(clip_val),
      .in_valid(in_valid && sel == 2), .in_ready(ir_v[2]), .in_data(in_data),
      .out_valid(ov_v[2]), .out_ready(out_ready), .out_data(od_v[2]), .out_last(ol_v[2]),
      .busy(bs_v[2]), .done(dn_v[2]));

   always_comb begin
      in_ready  = ir_v[0];
      out_valid = ov_v[0];
      out_last  = ol_v[0];
      busy      = bs_v[0];
      done      = dn_v[0];
      out_data  = od_v[0];
      case (sel)
         1: begin
            in_ready = ir_v[1]; out_valid = ov_v[1]; out_last = ol_v[1];
            busy = bs_v[1]; done = dn_v[1]; out_data = od_v[1];
         end
         2: begin
            in_ready = ir_v[2]; out_valid = ov_v[2]; out_last = ol_v[2];
            busy = bs_v[2]; done = dn_v[2]; out_data = od_v[2];
         end
         default: ;
      endcase
   end

   function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endfunction

   function automatic int num_of(input int s);
      return (s == 0) ? 8 : (s == 1) ? 6 : 784;
   endfunction

   // Reference model written with integer arithmetic (floor division for leaky).
   function automatic logic [15:0] model(input logic [15:0] x, input logic [1:0] m, input logic [15:0] c);
      int xi, ci, r;
      xi = int'($signed(x));
      ci = int'($signed(c));
      case (m)
         2'd0: r = (xi < 0) ? 0 : xi;
         2'd1: begin
            r = (xi < ci) ? xi : ci;
            if (r < 0) r = 0;
         end
         2'd2: begin
`ifdef ACT_LEAKY_EN
            r = (xi >= 0) ? xi : -((-xi + 7) / 8);
`else
            r = (xi < 0) ? 0 : xi;
`endif
         end
         default: r = xi;
      endcase
      return r[15:0];
   endfunction

   function automatic logic [127:0] v8(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
      return {a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   task automatic run_vec(input int s, input logic [1:0] m, input logic [15:0] c,
                          input int stall_pct, input string tag);
      int n, beats, bi, k, last_ho_k, n_done, budget, g;
      logic stalled_prev, prev_last, fin;
      logic [DW-1:0] prev_data, din, dexp;
      exp_t e;
      n = num_of(s);
      beats = (n + 3) / 4;
      sel = s;
      sbq.delete();
      mode = m; clip_val = c; start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "/idle_in_ready"}, 64'(in_ready), 64'(0));
      chk({tag, "/idle_busy"}, 64'(busy), 64'(0));
      @(posedge clk); #1;
      start = 1'b0;
      mode = m ^ 2'b11;
      clip_val = ~c;
      bi = 0; k = 1; last_ho_k = -10; n_done = 0; fin = 1'b0;
      stalled_prev = 1'b0; prev_last = 1'b0; prev_data = '0;
      budget = beats * 20 + 40;
      while (!fin && k < budget) begin
         in_valid = (bi < beats);
         din = '0;
         for (int l = 0; l < 4; l++) begin
            g = bi * 4 + l;
            din[l*16 +: 16] = (g < 800) ? vin[g] : 16'hBEEF;
         end
         in_data = din;
         out_ready = ($urandom_range(99) >= 32'(stall_pct));
         @(negedge clk);
         if (stalled_prev) begin
            chk({tag, "/stall_valid"}, 64'(out_valid), 64'(1));
            chk({tag, "/stall_data"}, out_data, prev_data);
            chk({tag, "/stall_last"}, 64'(out_last), 64'(prev_last));
         end
         if (out_valid && !out_ready) chk({tag, "/stall_in_ready"}, 64'(in_ready), 64'(0));
         chk({tag, "/busy"}, 64'(busy), 64'(!done));
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL %s/extra_beat: got %h expected no beat", tag, out_data);
            end else begin
               e = sbq.pop_front();
               chk({tag, "/data"}, out_data, e.data);
               chk({tag, "/last"}, 64'(out_last), 64'(e.last));
            end
            last_ho_k = k;
         end
         if (in_valid && in_ready) begin
            for (int l = 0; l < 4; l++) begin
               g = bi * 4 + l;
               dexp[l*16 +: 16] = (g < n) ? vexp[g] : 16'h0000;
            end
            e.data = dexp;
            e.last = (bi == beats - 1);
            sbq.push_back(e);
            bi++;
         end
         if (done) begin
            n_done++;
            chk({tag, "/done_after_last"}, 64'(k), 64'(last_ho_k + 1));
            if (stall_pct == 0) chk({tag, "/start_to_done"}, 64'(k), 64'(beats + 2));
            fin = 1'b1;
         end
         stalled_prev = out_valid && !out_ready;
         prev_data = out_data;
         prev_last = out_last;
         @(posedge clk); #1;
         k++;
      end
      if (!fin) begin
         n_cmp++; n_bad++;
         $display("FAIL %s/timeout: got no done after %0d cycles expected done", tag, k);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (done) n_done++;
         chk({tag, "/post_busy"}, 64'(busy), 64'(0));
         @(posedge clk); #1;
      end
      chk({tag, "/done_count"}, 64'(n_done), 64'(1));
      chk({tag, "/beats_in"}, 64'(bi), 64'(beats));
      chk({tag, "/sb_empty"}, 64'(sbq.size()), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] leaky_exp;
      reset = 1'b1; start = 1'b0; mode = 2'd0; clip_val = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1; sel = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset/in_ready", 64'(in_ready), 64'(0));
      chk("reset/out_valid", 64'(out_valid), 64'(0));
      chk("reset/out_data", out_data, 64'(0));
      chk("reset/out_last", 64'(out_last), 64'(0));
      chk("reset/busy", 64'(busy), 64'(0));
      chk("reset/done", 64'(done), 64'(0));
      @(posedge clk); #1;
      reset = 1'b0;

`ifdef ACT_LEAKY_EN
      leaky_exp = v8(16'hFFE0, 16'hFFFF, 16'h0180, 16'hF000, 16'hFFFF, 16'hFFFE, 16'h0008, 16'h0000);
`else
      leaky_exp = v8(16'h0000, 16'h0000, 16'h0180, 16'h0000, 16'h0000, 16'h0000, 16'h0008, 16'h0000);
`endif
      tbl.push_back('{0, 2'd0, 16'h0000,
         v8(16'h0180, 16'hFF00, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0100, 16'h0001),
         v8(16'h0180, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0100, 16'h0001)});
      tbl.push_back('{0, 2'd1, 16'h0600,
         v8(16'h0700, 16'h0500, 16'hFE00, 16'h0600, 16'h0601, 16'h7FFF, 16'h8000, 16'h05FF),
         v8(16'h0600, 16'h0500, 16'h0000, 16'h0600, 16'h0600, 16'h0600, 16'h0000, 16'h05FF)});
      tbl.push_back('{0, 2'd1, 16'hFF00,
         v8(16'h0700, 16'h0500, 16'hFE00, 16'h0600, 16'h0601, 16'h7FFF, 16'h8000, 16'h05FF),
         128'h0});
      tbl.push_back('{0, 2'd2, 16'h0000,
         v8(16'hFF00, 16'hFFFF, 16'h0180, 16'h8000, 16'hFFF8, 16'hFFF7, 16'h0008, 16'h0000),
         leaky_exp});
      tbl.push_back('{0, 2'd3, 16'h0000,
         v8(16'h8000, 16'hFFFF, 16'h1234, 16'h7FFF, 16'h0000, 16'h8001, 16'h00FF, 16'hFF01),
         v8(16'h8000, 16'hFFFF, 16'h1234, 16'h7FFF, 16'h0000, 16'h8001, 16'h00FF, 16'hFF01)});
      tbl.push_back('{1, 2'd3, 16'h0000,
         v8(16'hFFFF, 16'h0005, 16'h8000, 16'h0001, 16'h0100, 16'h0200, 16'h0300, 16'h0400),
         v8(16'hFFFF, 16'h0005, 16'h8000, 16'h0001, 16'h0100, 16'h0200, 16'h0000, 16'h0000)});
      tbl.push_back('{1, 2'd0, 16'h0000,
         v8(16'hFFFF, 16'h0005, 16'h8000, 16'h0001, 16'h0100, 16'h0200, 16'h0300, 16'h0400),
         v8(16'h0000, 16'h0005, 16'h0000, 16'h0001, 16'h0100, 16'h0200, 16'h0000, 16'h0000)});

      for (int pass = 0; pass < 2; pass++) begin
         foreach (tbl[i]) begin
            for (int g = 0; g < 8; g++) begin
               vin[g]  = tbl[i].din[g*16 +: 16];
               vexp[g] = tbl[i].dexp[g*16 +: 16];
            end
            run_vec(tbl[i].sel, tbl[i].mode, tbl[i].clip, pass * 40,
                    $sformatf("vec%0d_p%0d", i, pass));
         end
      end

      // Long vectors with random data and 30% backpressure.
      for (int r = 0; r < 2; r++) begin
         logic [1:0]  rm;
         logic [15:0] rc;
         rm = (r == 0) ? 2'd1 : 2'd2;
         rc = 16'h1000;
         for (int g = 0; g < 784; g++) begin
            vin[g]  = 16'($urandom);
            vexp[g] = model(vin[g], rm, rc);
         end
         run_vec(2, rm, rc, 30, $sformatf("rand%0d", r));
      end

      // Reset in the middle of RUN after five accepted beats.
      sel = 2; mode = 2'd0; clip_val = '0; out_ready = 1'b1; in_valid = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int b = 0; b < 5; b++) begin
         in_valid = 1'b1;
         in_data = {$urandom, $urandom};
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(negedge clk);
      chk("midrst/pre_busy", 64'(busy), 64'(1));
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst/in_ready", 64'(in_ready), 64'(0));
      chk("midrst/out_valid", 64'(out_valid), 64'(0));
      chk("midrst/out_data", out_data, 64'(0));
      chk("midrst/out_last", 64'(out_last), 64'(0));
      chk("midrst/busy", 64'(busy), 64'(0));
      chk("midrst/done", 64'(done), 64'(0));
      @(posedge clk); #1;
      reset = 1'b0;
      in_valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("midrst/no_done", 64'(done), 64'(0));
         @(posedge clk); #1;
      end

      // Start coincident with reset is dropped.
      reset = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst_start/busy", 64'(busy), 64'(0));
      @(posedge clk); #1;

      for (int g = 0; g < 784; g++) begin
         vin[g]  = 16'($urandom);
         vexp[g] = vin[g];
      end
      run_vec(2, 2'd3, 16'h0000, 10, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/act_stream.md
# act_stream

Streaming, multi-lane fixed-point activation unit that replaces the single-shot ReLU stage between MLP layers. It accepts a vector of NUM_ELEMS signed fixed-point values as LANES-wide beats over a valid/ready handshake. Each element is transformed by a run-time selected activation: ReLU, clipped ReLU, leaky ReLU or identity. Results leave through a registered, back-pressurable output stream with a last-beat marker and an end-of-vector done pulse.

## Interface
- NUM_ELEMS, 784, elements per vector
- LANES, 4, elements per beat; BEATS = ceil(NUM_ELEMS/LANES)
- FP_TOTAL_BITS, 16, fixed-point word width (two's complement)
- FP_FRAC_BITS, 8, fractional bits (informational; no rescaling performed)
- LEAK_SHIFT, 3, leaky slope = 2^-LEAK_SHIFT
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a vector, latches mode and clip_val
- mode  in  2  0 RELU, 1 RELU_CLIP, 2 LEAKY, 3 IDENTITY
- clip_val  in  FP_TOTAL_BITS  upper clamp for RELU_CLIP (signed)
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  LANES x FP_TOTAL_BITS  input lanes, lane 0 = lowest element index
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES x FP_TOTAL_BITS  activated lanes
- out_last  out  1  asserted with final beat of vector
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after final beat handed off

## Operation
- FSM states IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. On start, latch mode/clip_val, clear beat_cnt, go RUN. start is ignored outside IDLE.
- RUN: in_ready = !out_valid || out_ready. Each accepted beat is registered into the output stage and beat_cnt is incremented. When the beat with beat_cnt==BEATS-1 is accepted, go DRAIN.
- DRAIN: in_ready=0. Hold until the final beat is accepted (out_valid && out_ready && out_last), then go DONE.
- DONE: done=1 for exactly one cycle, busy=0, then go IDLE.
- Per-element function, with x the element:
  - RELU: x<0 gives 0, otherwise x.
  - RELU_CLIP: max(0, min(x, clip_val)). A negative clip_val yields 0 for every element.
  - LEAKY: x<0 gives x>>>LEAK_SHIFT (arithmetic shift, floor rounding), otherwise x.
  - IDENTITY: x.
- Final-beat padding lanes (global index >= NUM_ELEMS) output 0 regardless of input.
- No overflow is possible; every result fits FP_TOTAL_BITS.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, state IDLE, beat_cnt=0.
- Latency: 1 cycle from accepted input beat to out_valid.
- Throughput: 1 beat/cycle with out_ready held high; a full vector occupies BEATS+2 cycles from start to done.
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable and in_ready=0.
- Simultaneous output handoff and new input acceptance in the same cycle is legal and lossless.
- Reset mid-vector: aborts immediately to reset values, with no done pulse. In-flight data is discarded.
- start coincident with reset: reset wins.

## Configuration
- ACT_LEAKY_EN defined: the LEAKY mode, LEAK_SHIFT datapath and shifter are compiled in.
- ACT_LEAKY_EN undefined: mode 2 behaves exactly as RELU and no shifter logic is present. LEAK_SHIFT is accepted but unused.

## Structure
- mlp_pkg holds:
  - act_mode_e enum (RELU, RELU_CLIP, LEAKY, IDENTITY)
  - act_state_e enum
  - shared FP_TOTAL_BITS/FP_FRAC_BITS defaults
  - fixed-point zero constant
- act_lane is a purely combinational per-element function. It takes x, mode, clip_val and a pad flag and returns the result. The top instantiates it LANES times via generate. The top owns the FSM, counter and output register.

## Test plan
- RELU, LANES=4, NUM_ELEMS=8, beats {0x0180, 0xFF00, 0x0000, 0x8000} then {0x7FFF, 0xFFFF, 0x0100, 0x0001} -> {0x0180, 0, 0, 0} then {0x7FFF, 0, 0x0100, 0x0001}; out_last on beat 2; done pulses 1 cycle after that beat's handoff.
- RELU_CLIP with clip_val=0x0600: inputs {0x0700, 0x0500, 0xFE00, 0x0600} -> {0x0600, 0x0500, 0, 0x0600}. With clip_val=0xFF00: all outputs 0.
- LEAKY with ACT_LEAKY_EN, LEAK_SHIFT=3: inputs {0xFF00, 0xFFFF, 0x0180, 0x8000} -> {0xFFE0, 0xFFFF, 0x0180, 0xF000}. Without ACT_LEAKY_EN -> {0, 0, 0x0180, 0}.
- NUM_ELEMS=6, LANES=4: second beat inputs {0x0100, 0x0200, 0x0300, 0x0400} -> {0x0100, 0x0200, 0, 0}, with out_last=1.
- Random out_ready backpressure (30% low) over 784 elements: no data lost, reordered or duplicated; out_data is stable while stalled; exactly one done pulse.
- Reset asserted mid-RUN after beat 5 -> next cycle all outputs at reset values, no done pulse. A subsequent start completes a full vector normally.
